// File: rtl/sprite_pkg.sv
// sprite_pkg: shared OAM layout, secondary-array slot and sprite constants
package sprite_pkg;
  localparam int OAM_ADDR_SIZE = 8;
  localparam int OAM_DATA_SIZE = 32;
  localparam int SECOND_ARRAY_SIZE = 32;
  localparam int SPRITE_HEIGHT = 16;
  localparam int DISPLAY_HEIGHT = 480;
  localparam int LINE_NUMBER_WIDTH = $clog2(DISPLAY_HEIGHT);
  typedef struct packed {
    logic en;
    logic yflip;
    logic xflip;
    logic prio;
    logic [9:0] ypos;
    logic [9:0] xpos;
    logic [7:0] spriteref;
  } oam_entry_t;
  typedef struct packed {
    logic [OAM_ADDR_SIZE-1:0] addr;
    logic valid;
  } slot_t;
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} eval_state_t;
endpackage

// File: rtl/sprite_evaluator_if.sv
// sprite_evaluator_if: control, OAM bus and secondary array of the evaluator
interface sprite_evaluator_if;
  import sprite_pkg::*;
  logic enable;
  logic done;
  logic overflow;
  wire [OAM_ADDR_SIZE-1:0] oam_a;
  logic [OAM_DATA_SIZE-1:0] oam_d;
  logic [LINE_NUMBER_WIDTH-1:0] line_number;
  slot_t [SECOND_ARRAY_SIZE-1:0] second_array;
  modport master (output enable, oam_d, line_number, input done, overflow, oam_a, second_array);
  modport slave (input enable, oam_d, line_number, output done, overflow, oam_a, second_array);
endinterface

// File: rtl/sprite_line_match.sv
// sprite_line_match: enabled OAM entry vertically covers line_number
module sprite_line_match import sprite_pkg::*; (
  input  logic [LINE_NUMBER_WIDTH-1:0] line_number,
  input  oam_entry_t                   entry,
  output logic                         hit
);
  logic [10:0] diff;
  logic unused_fields;
  assign unused_fields = ^{entry.yflip, entry.xflip, entry.prio, entry.xpos, entry.spriteref};
  always_comb begin
    diff = 11'(line_number) - 11'(entry.ypos);
    hit = entry.en && diff < 11'(SPRITE_HEIGHT);
  end
endmodule

// File: rtl/sprite_evaluator.sv
// sprite_evaluator: scans OAM and packs covering sprites into the secondary array
module sprite_evaluator import sprite_pkg::*; (
  input logic clk,
  input logic rst,
  sprite_evaluator_if.slave bus
);
  localparam int IW = $clog2(SECOND_ARRAY_SIZE);
  localparam int CW = $clog2(SECOND_ARRAY_SIZE + 1);
  eval_state_t state_q, state_d;
  logic [OAM_ADDR_SIZE-1:0] addr_q, addr_d, addr_p_q, addr_p_d;
  logic [CW-1:0] count_q, count_d;
  logic valid_q, valid_d, done_q, done_d, overflow_q, overflow_d, hit;
  slot_t [SECOND_ARRAY_SIZE-1:0] arr_q, arr_d;
  sprite_line_match u_match (.line_number(bus.line_number), .entry(oam_entry_t'(bus.oam_d)), .hit(hit));
  assign bus.oam_a = state_q == SCAN ? addr_q : 'z;
  assign bus.done = done_q;
  assign bus.overflow = overflow_q;
  assign bus.second_array = arr_q;
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    addr_p_d = addr_q;
    count_d = count_q;
    overflow_d = overflow_q;
    arr_d = arr_q;
    valid_d = state_q == SCAN && bus.enable;
    done_d = state_q == DONE && bus.enable;
    if (state_q == IDLE && bus.enable) begin
      state_d = SCAN;
      addr_d = '0;
      count_d = '0;
      overflow_d = 1'b0;
      arr_d = '0;
    end
    if (state_q == SCAN) begin
      addr_d = addr_q + 1'b1;
      state_d = &addr_q ? DRAIN : SCAN;
    end
    if (state_q == DRAIN) state_d = DONE;
    // word returning now belongs to the address issued one cycle earlier
    if (valid_q && (state_q == SCAN || state_q == DRAIN) && hit) begin
      if (count_q == CW'(SECOND_ARRAY_SIZE)) begin
        overflow_d = 1'b1;
        state_d = DONE;
      end else begin
        arr_d[count_q[IW-1:0]] = {addr_p_q, 1'b1};
        count_d = count_q + 1'b1;
      end
    end
    if (!bus.enable) state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      addr_p_q <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      done_q <= 1'b0;
      overflow_q <= 1'b0;
      arr_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      addr_p_q <= addr_p_d;
      count_q <= count_d;
      valid_q <= valid_d;
      done_q <= done_d;
      overflow_q <= overflow_d;
      arr_q <= arr_d;
    end
  end
endmodule

// File: tb/tb_sprite_evaluator.sv
// tb_sprite_evaluator: directed checks of scan timing, window bounds, overflow, abort and reset
module tb_sprite_evaluator;
  logic clk = 1'b0;
  logic rst;
  logic [31:0] oam [256];
  int checks = 0;
  int failures = 0;
  int cyc;
  sprite_evaluator_if bus();
  sprite_evaluator dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) bus.oam_d <= oam[bus.oam_a];

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ent(logic en, logic [9:0] y);
    return {en, 3'b101, y, 10'd123, 8'd77};
  endfunction

  task automatic clear_oam();
    for (int i = 0; i < 256; i++) oam[i] = 32'h0;
  endtask

  task automatic setup_window();
    clear_oam();
    oam[3] = ent(1'b1, 10'd100);
    oam[5] = ent(1'b1, 10'd85);
    oam[6] = ent(1'b1, 10'd84);
    oam[7] = ent(1'b1, 10'd101);
    oam[9] = ent(1'b1, 10'd90);
    bus.line_number = 9'd100;
  endtask

  task automatic run_scan(output int c);
    bus.enable = 1'b1;
    c = -1;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        c = i;
        break;
      end
    end
  endtask

  task automatic release_en();
    bus.enable = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic check_window(string tag);
    check({tag, "_slot0"}, 64'(bus.second_array[0]), {8'd3, 1'b1});
    check({tag, "_slot1"}, 64'(bus.second_array[1]), {8'd5, 1'b1});
    check({tag, "_slot2"}, 64'(bus.second_array[2]), {8'd9, 1'b1});
    check({tag, "_slot3"}, 64'(bus.second_array[3]), 64'd0);
    check({tag, "_ovf"}, 64'(bus.overflow), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus.enable = 1'b0;
    bus.line_number = 9'd100;
    clear_oam();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_ovf", 64'(bus.overflow), 64'd0);
    check("rst_slots", 64'(bus.second_array == '0), 64'd1);
    check("rst_oam_a_z", 64'(bus.oam_a === 8'bz), 64'd1);
    run_scan(cyc);
    check("empty_latency", 64'(cyc), 64'd258);
    check("empty_slots", 64'(bus.second_array == '0), 64'd1);
    check("empty_ovf", 64'(bus.overflow), 64'd0);
    check("done_oam_a_z", 64'(bus.oam_a === 8'bz), 64'd1);
    release_en();
    check("release_done", 64'(bus.done), 64'd0);
    check("idle_oam_a_z", 64'(bus.oam_a === 8'bz), 64'd1);

    setup_window();
    run_scan(cyc);
    check("win_latency", 64'(cyc), 64'd258);
    check_window("win");
    release_en();

    clear_oam();
    oam[2] = ent(1'b0, 10'd0);
    oam[8] = ent(1'b0, 10'd50);
    oam[4] = ent(1'b1, 10'd1020);
    bus.line_number = 9'd2;
    run_scan(cyc);
    check("nohit_latency", 64'(cyc), 64'd258);
    check("nohit_slots", 64'(bus.second_array == '0), 64'd1);
    release_en();

    clear_oam();
    for (int i = 0; i < 40; i++) oam[i] = ent(1'b1, 10'd200);
    bus.line_number = 9'd205;
    run_scan(cyc);
    check("ovf_latency", 64'(cyc), 64'd35);
    check("ovf_flag", 64'(bus.overflow), 64'd1);
    for (int i = 0; i < 32; i++) check($sformatf("ovf_slot%0d", i), 64'(bus.second_array[i]), {i[7:0], 1'b1});
    release_en();

    setup_window();
    bus.enable = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    check("abort_pre_oam_a", 64'(bus.oam_a), 64'd49);
    bus.enable = 1'b0;
    @(posedge clk);
    #1;
    check("abort_done", 64'(bus.done), 64'd0);
    check("abort_oam_a_z", 64'(bus.oam_a === 8'bz), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    check("abort_idle_done", 64'(bus.done), 64'd0);
    run_scan(cyc);
    check("restart_latency", 64'(cyc), 64'd258);
    check_window("restart");
    release_en();

    bus.enable = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    bus.enable = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_done", 64'(bus.done), 64'd0);
    check("midrst_ovf", 64'(bus.overflow), 64'd0);
    check("midrst_slots", 64'(bus.second_array == '0), 64'd1);
    check("midrst_oam_a_z", 64'(bus.oam_a === 8'bz), 64'd1);
    run_scan(cyc);
    check("postrst_latency", 64'(cyc), 64'd258);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("hold_oam_a_z%0d", i), 64'(bus.oam_a === 8'bz), 64'd1);
      check($sformatf("hold_done%0d", i), 64'(bus.done), 64'd1);
    end
    check_window("hold");
    release_en();
    check("final_done", 64'(bus.done), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
